reveal_sequencer: RTL and testbench
===================================

REVEAL_SEQUENCER -- requirements
Module: reveal_sequencer

Interface
REQ-001 Parameter MODULES, default 7: number of display elements sequenced; one enable bit each, bit 0 revealed first.
REQ-002 Parameter STEP_FRAMES, default 30: frames between successive reveals; legal range 1..1023.
REQ-003 Parameter HOLD_FRAMES, default 120: frames spent in HOLD after the last reveal step; legal range 1..1023.
REQ-004 Parameter BLINK_FRAMES, default 15: frames per blink half-period; legal range 1..1023.
REQ-005 Parameter BLINK_MASK, default 7'b0000010, width MODULES: enable bits that toggle in BLINK.
REQ-006 Parameter VS_ACTIVE_LOW, default 1: 1 = VS sync pulse is low-active.
REQ-007 clk  input  1  pixel clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-009 vs  input  1  vertical sync from the VGA timing generator, same clock domain.
REQ-010 start  input  1  single-cycle pulse; begins or restarts the sequence.
REQ-011 stop  input  1  single-cycle pulse; aborts to IDLE.
REQ-012 pause  input  1  level; while 1, frame ticks are ignored.
REQ-013 enable  output  MODULES  per-element enable, driven to the enable inputs of the string display instances.
REQ-014 busy  output  1  1 in any state other than IDLE.
REQ-015 done  output  1  1 in HOLD and BLINK.

Function
REQ-016 frame_tick SHALL be a one-cycle internal pulse on the clock following vs transitioning from inactive to active level (one registered vs sample; no pulse on the first cycle after reset).
REQ-017 States SHALL be IDLE, REVEAL, HOLD, BLINK; enable, busy and done SHALL be registered outputs.
REQ-018 IDLE: enable=0; busy=0; done=0; the frame counter and the index counter are held at 0.
REQ-019 start from any state SHALL, on the next cycle, enter REVEAL with enable={MODULES-1 zeros, 1}, idx=1 and fcnt=0.
REQ-020 stop SHALL, on the next cycle, enter IDLE and clear enable; if start and stop arrive in the same cycle, stop wins.
REQ-021 In REVEAL, HOLD and BLINK, each frame_tick with pause=0 SHALL increment fcnt; a frame_tick that coincides with pause=1 is dropped, not deferred.
REQ-022 REVEAL: on a counted tick with fcnt==STEP_FRAMES-1, fcnt<=0; if idx<MODULES, set enable[idx] and increment idx; otherwise enter HOLD.
REQ-023 Result: the last element is enabled MODULES-1 steps after start, and HOLD is entered one further step later.
REQ-024 HOLD: all enable bits are 1; on a counted tick with fcnt==HOLD_FRAMES-1, enter BLINK with fcnt<=0 and the enable bits in BLINK_MASK cleared.
REQ-025 BLINK: on each counted tick with fcnt==BLINK_FRAMES-1, fcnt<=0 and the enable bits in BLINK_MASK invert; bits outside BLINK_MASK stay 1.
REQ-026 BLINK SHALL persist until start or stop.
REQ-027 STEP_FRAMES, HOLD_FRAMES or BLINK_FRAMES equal to 1 SHALL advance on every counted tick.
REQ-028 fcnt and idx SHALL be sized from the parameters with a ceiling-log2 function and SHALL never wrap past their terminal values.
REQ-029 pause SHALL freeze enable, fcnt, idx and state; start and stop remain effective while paused.
REQ-030 MODULES=1 SHALL be legal: REVEAL enables bit 0, then enters HOLD after one step.

Reset
REQ-031 Reset asserted (reset=0) SHALL immediately force IDLE, enable=0, busy=0, done=0, fcnt=0, idx=0 and the registered vs sample to the inactive level.
REQ-032 Reset mid-sequence SHALL discard all progress; after release, the block waits for a new start.

Verification (MODULES=3, STEP_FRAMES=2, HOLD_FRAMES=3, BLINK_FRAMES=1, BLINK_MASK=3'b010, VS_ACTIVE_LOW=1)
REQ-033 Release reset, pulse start -> the next cycle shows enable=001 and busy=1; after 2 ticks enable=011; after 4 ticks 111; after 6 ticks done=1.
REQ-034 From HOLD, 3 ticks -> BLINK with enable=101; each further tick toggles the bit: 111, 101, and so on.
REQ-035 Hold pause=1 over 5 vs pulses in REVEAL -> enable, state and counts unchanged; release pause -> progression resumes exactly where it stopped.
REQ-036 start and stop in the same cycle during BLINK -> IDLE, enable=000, busy=0, done=0.
REQ-037 Assert reset asynchronously mid-REVEAL, away from any clock edge -> outputs are 0 before the next clk edge; a vs pulse after release with no start -> enable stays 000.
REQ-038 Pulse start during HOLD -> the next cycle shows enable=001, done=0 and the sequence restarts from step 0.

Source files
------------

// File: rtl/reveal_sequencer.sv
// reveal_sequencer
//   Frame-paced reveal of MODULES display elements: one more element is
//   enabled every STEP_FRAMES frames. Once all elements are on, the block
//   holds for HOLD_FRAMES frames. It then blinks the BLINK_MASK elements
//   with a half-period of BLINK_FRAMES frames until start or stop.
// Ports
//   clk    : pixel clock, rising-edge active
//   reset  : asynchronous active-low reset
//   vs     : vertical sync, same clock domain (polarity set by VS_ACTIVE_LOW)
//   start  : single-cycle pulse, begins/restarts the sequence
//   stop   : single-cycle pulse, aborts to IDLE (wins over start)
//   pause  : level, frame ticks are ignored while high
//   enable : per-element enable, bit 0 revealed first (registered)
//   busy   : high in any state other than IDLE (registered)
//   done   : high in HOLD and BLINK (registered)
module reveal_sequencer #(
  parameter int                 MODULES       = 7,
  parameter int                 STEP_FRAMES   = 30,
  parameter int                 HOLD_FRAMES   = 120,
  parameter int                 BLINK_FRAMES  = 15,
  parameter logic [MODULES-1:0] BLINK_MASK    = MODULES'(7'b0000010),
  parameter bit                 VS_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vs,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  output logic [MODULES-1:0] enable,
  output logic               busy,
  output logic               done
);

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int MAX_FRAMES = (STEP_FRAMES > HOLD_FRAMES) ?
      ((STEP_FRAMES > BLINK_FRAMES) ? STEP_FRAMES : BLINK_FRAMES) :
      ((HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES);
  // fcnt holds 0..MAX_FRAMES-1, idx holds 0..MODULES
  localparam int FW = (clog2_f(MAX_FRAMES) < 1) ? 1 : clog2_f(MAX_FRAMES);
  localparam int IW = (clog2_f(MODULES + 1) < 1) ? 1 : clog2_f(MODULES + 1);

  localparam logic [FW-1:0]      STEP_TERM  = FW'(STEP_FRAMES - 1);
  localparam logic [FW-1:0]      HOLD_TERM  = FW'(HOLD_FRAMES - 1);
  localparam logic [FW-1:0]      BLINK_TERM = FW'(BLINK_FRAMES - 1);
  localparam logic [IW-1:0]      IDX_LAST   = IW'(MODULES);
  localparam logic [MODULES-1:0] ALL_ONES   = {MODULES{1'b1}};
  localparam logic               VS_IDLE    = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    HOLD   = 2'd2,
    BLINK  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [MODULES-1:0] enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               vs_q;
  logic               frame_tick_q, frame_tick_d;
  logic               vs_act_s, vs_q_act_s, count_s, term_s;

  // Frame tick: rising edge of the active vs level, delayed by one register
  // so nothing fires on the first cycle after reset.
  assign vs_act_s     = VS_ACTIVE_LOW ? ~vs : vs;
  assign vs_q_act_s   = VS_ACTIVE_LOW ? ~vs_q : vs_q;
  assign frame_tick_d = vs_act_s & ~vs_q_act_s;

  // A tick only counts outside IDLE and when not paused; paused ticks are lost.
  assign count_s = frame_tick_q & ~pause & (state_q != IDLE);

  // Terminal-count detect for the frame counter of the current state
  always_comb begin
    term_s = 1'b0;
    case (state_q)
      REVEAL:  term_s = (fcnt_q == STEP_TERM);
      HOLD:    term_s = (fcnt_q == HOLD_TERM);
      BLINK:   term_s = (fcnt_q == BLINK_TERM);
      default: term_s = 1'b0;
    endcase
  end

  // State, counters, vs sample and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      idx_q        <= '0;
      enable_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vs_q         <= VS_IDLE;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      idx_q        <= idx_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vs_q         <= vs;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Next state and counter updates
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    idx_d   = idx_q;
    if (stop) begin
      state_d = IDLE;
      fcnt_d  = '0;
      idx_d   = '0;
    end else if (start) begin
      state_d = REVEAL;
      fcnt_d  = '0;
      idx_d   = IW'(1);
    end else if (count_s) begin
      if (term_s) begin
        fcnt_d = '0;
        case (state_q)
          REVEAL: begin
            if (idx_q < IDX_LAST) begin
              idx_d = idx_q + IW'(1);
            end else begin
              state_d = HOLD;
            end
          end
          HOLD:    state_d = BLINK;
          BLINK:   state_d = BLINK;
          default: state_d = IDLE;
        endcase
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end else if (state_q == IDLE) begin
      fcnt_d = '0;
      idx_d  = '0;
    end else begin
      state_d = state_q;
    end
  end

  // Output values for the next cycle
  always_comb begin
    enable_d = enable_q;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == HOLD) || (state_d == BLINK);
    if (stop) begin
      enable_d = '0;
    end else if (start) begin
      enable_d = MODULES'(1'b1);
    end else begin
      case (state_q)
        IDLE: enable_d = '0;
        REVEAL: begin
          if (count_s && term_s && (idx_q < IDX_LAST)) begin
            for (int i = 0; i < MODULES; i++) begin
              if (idx_q == IW'(i)) begin
                enable_d[i] = 1'b1;
              end else begin
                enable_d[i] = enable_q[i];
              end
            end
          end else begin
            enable_d = enable_q;
          end
        end
        HOLD: begin
          if (count_s && term_s) begin
            enable_d = ALL_ONES & ~BLINK_MASK;
          end else begin
            enable_d = ALL_ONES;
          end
        end
        BLINK: begin
          // Masked bits toggle; everything else is forced on.
          if (count_s && term_s) begin
            enable_d = (enable_q ^ BLINK_MASK) | ~BLINK_MASK;
          end else begin
            enable_d = enable_q;
          end
        end
        default: enable_d = '0;
      endcase
    end
  end

  assign enable = enable_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_reveal_sequencer.sv
module tb_reveal_sequencer;

  localparam int             M     = 3;
  localparam int             STEP  = 2;
  localparam int             HOLDF = 3;
  localparam int             BLNK  = 1;
  localparam logic [M-1:0]   MASK  = 3'b010;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         vs = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic [M-1:0] enable;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];

  // reference model: phase 0 idle, 1 reveal, 2 hold, 3 blink
  int m_mode = 0;
  int m_count = 0;
  int m_shown = 0;
  int m_blink_on = 0;
  int m_prev_act = 0;
  int m_tick = 0;

  reveal_sequencer #(
    .MODULES(M), .STEP_FRAMES(STEP), .HOLD_FRAMES(HOLDF),
    .BLINK_FRAMES(BLNK), .BLINK_MASK(MASK), .VS_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .vs(vs), .start(start), .stop(stop),
    .pause(pause), .enable(enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_shown = 0; m_blink_on = 0;
    m_prev_act = 0; m_tick = 0;
  endtask

  task automatic model_step(input logic v, input logic st, input logic sp,
                            input logic ps, output logic [4:0] e);
    int counted;
    int act;
    logic [M-1:0] en;
    counted = (m_tick != 0 && !ps && m_mode != 0) ? 1 : 0;
    if (sp) begin
      m_mode = 0; m_count = 0; m_shown = 0;
    end else if (st) begin
      m_mode = 1; m_count = 0; m_shown = 1;
    end else if (counted != 0) begin
      m_count = m_count + 1;
      if (m_mode == 1 && m_count == STEP) begin
        m_count = 0;
        if (m_shown < M) m_shown = m_shown + 1;
        else m_mode = 2;
      end else if (m_mode == 2 && m_count == HOLDF) begin
        m_count = 0; m_mode = 3; m_blink_on = 0;
      end else if (m_mode == 3 && m_count == BLNK) begin
        m_count = 0; m_blink_on = 1 - m_blink_on;
      end
    end
    act = (v == 1'b0) ? 1 : 0;
    m_tick = (act != 0 && m_prev_act == 0) ? 1 : 0;
    m_prev_act = act;
    case (m_mode)
      1:       en = M'((1 << m_shown) - 1);
      2:       en = {M{1'b1}};
      3:       en = (m_blink_on != 0) ? {M{1'b1}} : ({M{1'b1}} & ~MASK);
      default: en = '0;
    endcase
    e = {en, (m_mode != 0) ? 1'b1 : 1'b0, (m_mode >= 2) ? 1'b1 : 1'b0};
  endtask

  task automatic cycle(input logic v, input logic st, input logic sp, input logic ps);
    logic [4:0] e;
    @(negedge clk);
    vs = v; start = st; stop = sp; pause = ps;
    if (reset) begin
      model_step(v, st, sp, ps, e);
      exp_q.push_back(e);
    end else begin
      model_reset();
    end
  endtask

  task automatic frame(input logic ps, input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, 1'b0, 1'b0, ps);
      cycle(1'b1, 1'b0, 1'b0, ps);
      cycle(1'b1, 1'b0, 1'b0, ps);
      cycle(1'b0, 1'b0, 1'b0, ps);
      cycle(1'b0, 1'b0, 1'b0, ps);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({enable, busy, done} !== 5'b00000) begin
      errors++;
      $display("FAIL %s actual enable=%b busy=%b done=%b required all zero",
               name, enable, busy, done);
    end
  endtask

  // Monitor: compares the registered outputs after each active edge
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({enable, busy, done} !== e) begin
          errors++;
          $display("FAIL sb_outputs t=%0t actual enable=%b busy=%b done=%b required enable=%b busy=%b done=%b",
                   $time, enable, busy, done, e[4:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic v_r, ps_r, st, sp;
    #1 reset = 1'b0;
    #2 check_zero("reset_state");
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #2 reset = 1'b1;

    // full sequence: reveal, hold, blink
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 12);
    // start and stop together in BLINK
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    frame(1'b0, 2);
    // pause in REVEAL over 5 pulses, then resume
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 2);
    frame(1'b1, 5);
    frame(1'b0, 6);
    // restart from HOLD
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 7);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    frame(1'b0, 3);
    // asynchronous reset mid-REVEAL, away from the clock edge
    @(negedge clk); #2 reset = 1'b0;
    exp_q.delete();
    #1 check_zero("async_reset");
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #2 reset = 1'b1;
    frame(1'b0, 3);

    // randomized traffic
    v_r = 1'b1; ps_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) v_r = ~v_r;
      if ($urandom_range(0, 24) == 0) ps_r = ~ps_r;
      st = ($urandom_range(0, 199) == 0);
      sp = ($urandom_range(0, 399) == 0);
      cycle(v_r, st, sp, ps_r);
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
